ifmap_window_scheduler: RTL and testbench

IFMAP_WINDOW_SCHEDULER -- requirements
Module: ifmap_window_scheduler

---
 rtl/ifmap_window_scheduler_if.sv | 30 +++
 rtl/ifmap_window_scheduler.sv | 114 +++++++++++
 tb/tb_ifmap_window_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifmap_window_scheduler_if.sv
// Bundle of control, row-descriptor and scratchpad-address signals.
// Links the IFMap window scheduler to its fill controller and MAC datapath.
interface ifmap_window_scheduler_if #(
  parameter int SPAD_ADDR_WIDTH = 2
);
  logic                       init;
  logic                       stall;
  logic                       row_valid;
  logic [SPAD_ADDR_WIDTH-1:0] start_data;
  logic [SPAD_ADDR_WIDTH-1:0] end_data;
  logic [SPAD_ADDR_WIDTH:0]   filter_size;
  logic [SPAD_ADDR_WIDTH:0]   stride;
  logic [SPAD_ADDR_WIDTH-1:0] ifmap_raddr;
  logic [SPAD_ADDR_WIDTH:0]   filt_raddr;
  logic                       mac_en;
  logic                       acc_clr;
  logic                       out_valid;
  logic                       done;
  logic                       busy;

  modport master (
    output init, stall, row_valid, start_data, end_data, filter_size, stride,
    input  ifmap_raddr, filt_raddr, mac_en, acc_clr, out_valid, done, busy
  );

  modport slave (
    input  init, stall, row_valid, start_data, end_data, filter_size, stride,
    output ifmap_raddr, filt_raddr, mac_en, acc_clr, out_valid, done, busy
  );
endinterface

// File: rtl/ifmap_window_scheduler.sv
// Walks a resident IFMap row through F-tap sliding windows with stride S,
// issuing scratchpad read addresses and MAC control, one window at a time.
module ifmap_window_scheduler #(
  parameter int SPAD_ADDR_WIDTH = 2,
  parameter int SPAD_DEPTH      = 4
) (
  input logic                     clk,
  input logic                     rst,
  ifmap_window_scheduler_if.slave bus
);
  localparam int AW = SPAD_ADDR_WIDTH;
  localparam int CW = SPAD_ADDR_WIDTH + 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_ROW = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_COMPUTE  = 3'd3;
  localparam logic [2:0] S_ROW_END  = 3'd4;

  logic [2:0]    r_state;
  logic [AW-1:0] r_start;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_filt;
  logic [CW-1:0] r_stride;
  logic [CW-1:0] r_off;
  logic [CW-1:0] r_k;
  logic          r_outValid;

  logic [CW-1:0] w_span;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_stride;
  logic [CW-1:0] w_reach;
  logic          w_fits;
  logic          w_lastTap;
  logic [AW-1:0] w_addr;

  // Row length wraps modulo the scratchpad depth, so end < start is a wrapped row.
  assign w_span    = (CW'(bus.end_data) - CW'(bus.start_data)) & CW'(SPAD_DEPTH - 1);
  assign w_len     = w_span + CW'(1);
  assign w_stride  = (bus.stride == '0) ? CW'(1) : CW'(bus.stride);
  assign w_reach   = r_off + r_filt;
  assign w_fits    = (w_reach <= r_len);
  assign w_lastTap = (r_k == (r_filt - CW'(1)));
  assign w_addr    = AW'(CW'(r_start) + r_off + r_k);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_start    <= '0;
      r_len      <= '0;
      r_filt     <= '0;
      r_stride   <= '0;
      r_off      <= '0;
      r_k        <= '0;
      r_outValid <= 1'b0;
    end else if (!bus.stall) begin
      r_outValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.init) r_state <= S_WAIT_ROW;
        end
        S_WAIT_ROW: begin
          if (bus.row_valid) begin
            r_start  <= bus.start_data;
            r_len    <= w_len;
            r_filt   <= CW'(bus.filter_size);
            r_stride <= w_stride;
            r_off    <= '0;
            r_k      <= '0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_k     <= '0;
          r_state <= w_fits ? S_COMPUTE : S_ROW_END;
        end
        S_COMPUTE: begin
          // The result pulse rides on the following LOAD cycle.
          if (w_lastTap) begin
            r_outValid <= 1'b1;
            r_off      <= r_off + r_stride;
            r_k        <= '0;
            r_state    <= S_LOAD;
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        S_ROW_END: begin
          r_state <= S_WAIT_ROW;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.ifmap_raddr = '0;
    bus.filt_raddr  = '0;
    bus.mac_en      = 1'b0;
    bus.acc_clr     = 1'b0;
    if (r_state == S_COMPUTE) begin
      bus.ifmap_raddr = w_addr;
      bus.filt_raddr  = r_k[AW:0];
      bus.mac_en      = 1'b1;
      bus.acc_clr     = (r_k == '0);
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.done      = (r_state == S_ROW_END);
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_ifmap_window_scheduler.sv
// Directed bench for ifmap_window_scheduler: each task runs one scenario
// and compares the recorded tap trace with hand-computed windows.
module tb_ifmap_window_scheduler;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ifmap_window_scheduler_if #(.SPAD_ADDR_WIDTH(2)) bus ();

  ifmap_window_scheduler #(
    .SPAD_ADDR_WIDTH(2),
    .SPAD_DEPTH     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int macAddr[$];
  int macFilt[$];
  int macClr[$];
  int stallAddr[$];
  int stallFilt[$];
  int stallMac[$];
  int ovCount;
  int doneCount;
  int doneCycle;
  int ovAfterLastTap;
  int idleLeak;
  int timedOut;

  // Windows for start=0, end=3, F=2, S=1: (0,1) (1,2) (2,3)
  int basicAddr[6] = '{0, 1, 1, 2, 2, 3};
  int basicFilt[6] = '{0, 1, 0, 1, 0, 1};
  int basicClr[6]  = '{1, 0, 1, 0, 1, 0};

  task automatic doInit();
    @(negedge clk);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
  endtask

  // Presents one row and records every unstalled cycle until done settles.
  task automatic applyStimulus(input int s, input int e, input int f, input int st,
                               input int stallAt, input int stallLen);
    int c;
    int remain;
    int prevMac;
    int prevFilt;
    bit finished;
    c = 0; remain = 0; prevMac = 0; prevFilt = 0; finished = 1'b0;
    macAddr.delete(); macFilt.delete(); macClr.delete();
    stallAddr.delete(); stallFilt.delete(); stallMac.delete();
    ovCount = 0; doneCount = 0; doneCycle = 0; ovAfterLastTap = 0;
    idleLeak = 0; timedOut = 0;
    @(negedge clk);
    bus.start_data  = 2'(s);
    bus.end_data    = 2'(e);
    bus.filter_size = 3'(f);
    bus.stride      = 3'(st);
    bus.row_valid   = 1'b1;
    for (int n = 0; n < 200 && !finished; n++) begin
      @(negedge clk);
      bus.row_valid = 1'b0;
      if (bus.stall) begin
        stallAddr.push_back(int'(bus.ifmap_raddr));
        stallFilt.push_back(int'(bus.filt_raddr));
        stallMac.push_back(int'(bus.mac_en));
      end else begin
        c++;
        if (bus.mac_en) begin
          macAddr.push_back(int'(bus.ifmap_raddr));
          macFilt.push_back(int'(bus.filt_raddr));
          macClr.push_back(int'(bus.acc_clr));
        end else if (bus.ifmap_raddr != 0 || bus.filt_raddr != 0 || bus.acc_clr) begin
          idleLeak++;
        end
        if (bus.out_valid) begin
          ovCount++;
          if (prevMac == 1 && prevFilt == f - 1) ovAfterLastTap++;
        end
        if (bus.done) begin
          doneCount++;
          if (doneCycle == 0) doneCycle = c;
        end
        prevMac  = int'(bus.mac_en);
        prevFilt = int'(bus.filt_raddr);
        if (c == stallAt) remain = stallLen;
      end
      if (remain > 0) begin
        bus.stall = 1'b1;
        remain--;
      end else begin
        bus.stall = 1'b0;
      end
      if (doneCycle > 0 && c >= doneCycle + 3) finished = 1'b1;
    end
    if (!finished) timedOut = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.init = 1'b0; bus.stall = 1'b0; bus.row_valid = 1'b0;
    bus.start_data = '0; bus.end_data = '0; bus.filter_size = 3'd1; bus.stride = 3'd1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.mac_en, bus.acc_clr, bus.out_valid, bus.done} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {bus.busy, bus.mac_en, bus.acc_clr, bus.out_valid, bus.done});
    end
    checks++;
    if ({bus.ifmap_raddr, bus.filt_raddr} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %0d/%0d expected 0/0", bus.ifmap_raddr, bus.filt_raddr);
    end
    rst = 1'b1;
    @(negedge clk);
    bus.end_data = 2'd3; bus.filter_size = 3'd2; bus.row_valid = 1'b1;
    @(negedge clk);
    bus.row_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.mac_en, bus.out_valid, bus.done} !== 4'b0) begin
        errors++;
        $display("[TB] FAIL no_init_idle: cycle %0d got %b expected 0000", i,
                 {bus.busy, bus.mac_en, bus.out_valid, bus.done});
      end
    end
    doInit();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_busy: got %b expected 1", bus.busy);
    end
  endtask

  task automatic test_basic_row();
    applyStimulus(0, 3, 2, 1, 0, 0);
    checks++;
    if (timedOut != 0 || macAddr.size() != 6) begin
      errors++;
      $display("[TB] FAIL basic_taps: got %0d taps (timeout %0d) expected 6", macAddr.size(), timedOut);
    end
    for (int i = 0; i < 6 && i < macAddr.size(); i++) begin
      checks++;
      if (macAddr[i] != basicAddr[i] || macFilt[i] != basicFilt[i] || macClr[i] != basicClr[i]) begin
        errors++;
        $display("[TB] FAIL basic_tap%0d: got addr %0d k %0d clr %0d expected %0d %0d %0d", i,
                 macAddr[i], macFilt[i], macClr[i], basicAddr[i], basicFilt[i], basicClr[i]);
      end
    end
    checks++;
    if (ovCount != 3 || ovAfterLastTap != 3 || doneCount != 1 || idleLeak != 0) begin
      errors++;
      $display("[TB] FAIL basic_pulses: got ov %0d/%0d done %0d leak %0d expected 3/3 1 0",
               ovCount, ovAfterLastTap, doneCount, idleLeak);
    end
  endtask

  task automatic test_wrap();
    int expAddr[6] = '{2, 3, 0, 3, 0, 1};
    int expFilt[6] = '{0, 1, 2, 0, 1, 2};
    int expClr[6]  = '{1, 0, 0, 1, 0, 0};
    applyStimulus(2, 1, 3, 1, 0, 0);
    checks++;
    if (timedOut != 0 || macAddr.size() != 6) begin
      errors++;
      $display("[TB] FAIL wrap_taps: got %0d taps (timeout %0d) expected 6", macAddr.size(), timedOut);
    end
    for (int i = 0; i < 6 && i < macAddr.size(); i++) begin
      checks++;
      if (macAddr[i] != expAddr[i] || macFilt[i] != expFilt[i] || macClr[i] != expClr[i]) begin
        errors++;
        $display("[TB] FAIL wrap_tap%0d: got addr %0d k %0d clr %0d expected %0d %0d %0d", i,
                 macAddr[i], macFilt[i], macClr[i], expAddr[i], expFilt[i], expClr[i]);
      end
    end
    checks++;
    if (ovCount != 2 || ovAfterLastTap != 2 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL wrap_pulses: got ov %0d/%0d done %0d expected 2/2 1",
               ovCount, ovAfterLastTap, doneCount);
    end
  endtask

  task automatic test_short_row();
    applyStimulus(0, 1, 3, 1, 0, 0);
    checks++;
    if (macAddr.size() != 0 || ovCount != 0) begin
      errors++;
      $display("[TB] FAIL short_taps: got %0d taps %0d ov expected 0 0", macAddr.size(), ovCount);
    end
    checks++;
    if (timedOut != 0 || doneCount != 1 || doneCycle != 2) begin
      errors++;
      $display("[TB] FAIL short_done: got count %0d at cycle %0d (timeout %0d) expected 1 at 2",
               doneCount, doneCycle, timedOut);
    end
  endtask

  task automatic test_stride();
    int expAddr[4] = '{0, 1, 2, 3};
    int expFilt[4] = '{0, 1, 0, 1};
    int expClr[4]  = '{1, 0, 1, 0};
    applyStimulus(0, 3, 2, 2, 0, 0);
    checks++;
    if (timedOut != 0 || macAddr.size() != 4 || ovCount != 2 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL stride2_shape: got taps %0d ov %0d done %0d expected 4 2 1",
               macAddr.size(), ovCount, doneCount);
    end
    for (int i = 0; i < 4 && i < macAddr.size(); i++) begin
      checks++;
      if (macAddr[i] != expAddr[i] || macFilt[i] != expFilt[i] || macClr[i] != expClr[i]) begin
        errors++;
        $display("[TB] FAIL stride2_tap%0d: got addr %0d k %0d clr %0d expected %0d %0d %0d", i,
                 macAddr[i], macFilt[i], macClr[i], expAddr[i], expFilt[i], expClr[i]);
      end
    end
    applyStimulus(0, 3, 2, 0, 0, 0);
    checks++;
    if (timedOut != 0 || macAddr.size() != 6 || ovCount != 3 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL stride0_shape: got taps %0d ov %0d done %0d expected 6 3 1",
               macAddr.size(), ovCount, doneCount);
    end
    for (int i = 0; i < 6 && i < macAddr.size(); i++) begin
      checks++;
      if (macAddr[i] != basicAddr[i] || macFilt[i] != basicFilt[i]) begin
        errors++;
        $display("[TB] FAIL stride0_tap%0d: got addr %0d k %0d expected %0d %0d", i,
                 macAddr[i], macFilt[i], basicAddr[i], basicFilt[i]);
      end
    end
  endtask

  task automatic test_stall();
    applyStimulus(0, 3, 2, 1, 5, 3);
    checks++;
    if (timedOut != 0 || macAddr.size() != 6 || ovCount != 3 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL stall_shape: got taps %0d ov %0d done %0d expected 6 3 1",
               macAddr.size(), ovCount, doneCount);
    end
    for (int i = 0; i < 6 && i < macAddr.size(); i++) begin
      checks++;
      if (macAddr[i] != basicAddr[i] || macFilt[i] != basicFilt[i] || macClr[i] != basicClr[i]) begin
        errors++;
        $display("[TB] FAIL stall_tap%0d: got addr %0d k %0d clr %0d expected %0d %0d %0d", i,
                 macAddr[i], macFilt[i], macClr[i], basicAddr[i], basicFilt[i], basicClr[i]);
      end
    end
    checks++;
    if (stallAddr.size() != 3) begin
      errors++;
      $display("[TB] FAIL stall_len: got %0d stalled cycles expected 3", stallAddr.size());
    end
    for (int i = 0; i < stallAddr.size(); i++) begin
      checks++;
      if (stallAddr[i] != 1 || stallFilt[i] != 0 || stallMac[i] != 1) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got addr %0d k %0d mac %0d expected 1 0 1", i,
                 stallAddr[i], stallFilt[i], stallMac[i]);
      end
    end
  endtask

  task automatic test_init_ignored();
    @(negedge clk);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.mac_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL init_ignored: got busy %b done %b mac %b expected 1 0 0",
               bus.busy, bus.done, bus.mac_en);
    end
    applyStimulus(0, 1, 3, 1, 0, 0);
    checks++;
    if (doneCount != 1 || doneCycle != 2) begin
      errors++;
      $display("[TB] FAIL init_ignored_row: got done %0d at %0d expected 1 at 2", doneCount, doneCycle);
    end
  endtask

  task automatic test_reset_mid_compute();
    @(negedge clk);
    bus.start_data = 2'd0; bus.end_data = 2'd3; bus.filter_size = 3'd2; bus.stride = 3'd1;
    bus.row_valid = 1'b1;
    @(negedge clk);
    bus.row_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mac_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_compute: got mac_en %b expected 1", bus.mac_en);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.mac_en, bus.acc_clr, bus.out_valid, bus.done, bus.ifmap_raddr, bus.filt_raddr} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected 0",
               {bus.busy, bus.mac_en, bus.acc_clr, bus.out_valid, bus.done, bus.ifmap_raddr, bus.filt_raddr});
    end
    @(negedge clk);
    rst = 1'b1;
    bus.row_valid = 1'b1;
    @(negedge clk);
    bus.row_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.mac_en, bus.out_valid, bus.done} !== 4'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle: cycle %0d got %b expected 0000", i,
                 {bus.busy, bus.mac_en, bus.out_valid, bus.done});
      end
    end
    doInit();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_init: got busy %b expected 1", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_wrap();
    test_short_row();
    test_stride();
    test_stall();
    test_init_ignored();
    test_reset_mid_compute();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
